// File: rtl/scara_pkg.sv
// Shared types and constants for the SCARA joint step controller.
package scara_pkg;

    localparam int ANGLE_W = 13;
    localparam int DELTA_W = ANGLE_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIR_SETUP,
        ST_STEPPING,
        ST_DONE
    } state_t;

    function automatic logic [DELTA_W-1:0] absDelta(input logic signed [DELTA_W-1:0] d);
        return d[DELTA_W-1] ? DELTA_W'(-d) : DELTA_W'(d);
    endfunction

endpackage

// File: rtl/step_pulse_gen.sv
// Per-joint step generator: holds the remaining step count, direction and the
// registered step output, advanced by the controller's shared phase strobes.
module step_pulse_gen
    import scara_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_dir,
    input  logic [DELTA_W-1:0] i_remaining,
    input  logic               i_start,
    input  logic               i_endHigh,
    input  logic               i_endLow,
    output logic               o_step,
    output logic               o_dir,
    output logic               o_advance,
    output logic               o_last
);

    logic [DELTA_W-1:0] r_rem;
    logic               r_dir;
    logic               r_step;

    assign o_advance = i_endLow && (r_rem != '0);
    assign o_last    = (r_rem <= DELTA_W'(1));
    assign o_step    = r_step;
    assign o_dir     = r_dir;

    // A new step is raised on the last low cycle only if another one remains,
    // so the final period ends with the output already low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rem  <= '0;
            r_dir  <= 1'b0;
            r_step <= 1'b0;
        end else if (i_load) begin
            r_rem  <= i_remaining;
            r_dir  <= i_dir;
            r_step <= 1'b0;
        end else if (i_start) begin
            r_step <= (r_rem != '0);
        end else if (i_endHigh) begin
            r_step <= 1'b0;
        end else if (o_advance) begin
            r_rem  <= r_rem - DELTA_W'(1);
            r_step <= (r_rem > DELTA_W'(1));
        end
    end

endmodule

// File: rtl/joint_step_controller.sv
// Two-joint stepper move controller: captures a target on an angleValid rise,
// sets direction, then steps both joints concurrently on a shared phase.
module joint_step_controller
    import scara_pkg::*;
#(
    parameter int STEP_HALF_PERIOD = 500,
    parameter int DIR_SETUP        = 10
)
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [ANGLE_W-1:0] th1,
    input  logic signed [ANGLE_W-1:0] th2,
    input  logic                      angleValid,
    input  logic                      home,
    output logic                      step1,
    output logic                      step2,
    output logic                      dir1,
    output logic                      dir2,
    output logic signed [ANGLE_W-1:0] pos1,
    output logic signed [ANGLE_W-1:0] pos2,
    output logic                      busy,
    output logic                      done
);

    localparam logic [31:0] CNT_SETUP_LAST = 32'(DIR_SETUP - 1);
    localparam logic [31:0] CNT_HIGH_LAST  = 32'(STEP_HALF_PERIOD - 1);
    localparam logic [31:0] CNT_LOW_LAST   = 32'(2 * STEP_HALF_PERIOD - 1);

    state_t                    r_state;
    state_t                    w_next;
    logic                      r_armed;
    logic                      r_busy;
    logic                      r_done;
    logic [31:0]               r_cnt;
    logic signed [ANGLE_W-1:0] r_tgt1;
    logic signed [ANGLE_W-1:0] r_tgt2;
    logic signed [ANGLE_W-1:0] r_pos1;
    logic signed [ANGLE_W-1:0] r_pos2;

    logic signed [DELTA_W-1:0] w_delta1;
    logic signed [DELTA_W-1:0] w_delta2;
    logic w_rise, w_accept, w_zero, w_load, w_start, w_endHigh, w_endLow;
    logic w_step1, w_step2, w_dir1, w_dir2;
    logic w_adv1, w_adv2, w_last1, w_last2;

    // r_armed clears on reset, so a level already high then must drop first.
    assign w_rise    = angleValid && r_armed;
    assign w_accept  = (r_state == ST_IDLE) && !home && w_rise;
    assign w_delta1  = {r_tgt1[ANGLE_W-1], r_tgt1} - {r_pos1[ANGLE_W-1], r_pos1};
    assign w_delta2  = {r_tgt2[ANGLE_W-1], r_tgt2} - {r_pos2[ANGLE_W-1], r_pos2};
    assign w_zero    = (w_delta1 == '0) && (w_delta2 == '0);
    assign w_load    = (r_state == ST_LOAD);
    assign w_start   = (r_state == ST_DIR_SETUP) && (r_cnt == CNT_SETUP_LAST);
    assign w_endHigh = (r_state == ST_STEPPING) && (r_cnt == CNT_HIGH_LAST);
    assign w_endLow  = (r_state == ST_STEPPING) && (r_cnt == CNT_LOW_LAST);

    step_pulse_gen u_joint1 (
        .clk(clk), .reset(reset), .i_load(w_load), .i_dir(w_delta1[DELTA_W-1]),
        .i_remaining(absDelta(w_delta1)), .i_start(w_start), .i_endHigh(w_endHigh),
        .i_endLow(w_endLow), .o_step(w_step1), .o_dir(w_dir1), .o_advance(w_adv1),
        .o_last(w_last1)
    );

    step_pulse_gen u_joint2 (
        .clk(clk), .reset(reset), .i_load(w_load), .i_dir(w_delta2[DELTA_W-1]),
        .i_remaining(absDelta(w_delta2)), .i_start(w_start), .i_endHigh(w_endHigh),
        .i_endLow(w_endLow), .o_step(w_step2), .o_dir(w_dir2), .o_advance(w_adv2),
        .o_last(w_last2)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_accept) w_next = ST_LOAD;
            ST_LOAD:      w_next = w_zero ? ST_DONE : ST_DIR_SETUP;
            ST_DIR_SETUP: if (w_start) w_next = ST_STEPPING;
            ST_STEPPING:  if (w_endLow && w_last1 && w_last2) w_next = ST_DONE;
            ST_DONE:      w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_armed <= !angleValid;
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (r_state == ST_DONE);
        end
    end

    // One counter serves as the setup timer and then as the shared step phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (((r_state == ST_DIR_SETUP) && !w_start) ||
                     ((r_state == ST_STEPPING) && !w_endLow)) begin
            r_cnt <= r_cnt + 32'd1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tgt1 <= '0;
            r_tgt2 <= '0;
            r_pos1 <= '0;
            r_pos2 <= '0;
        end else begin
            if (w_accept) begin
                r_tgt1 <= th1;
                r_tgt2 <= th2;
            end
            if ((r_state == ST_IDLE) && home) begin
                r_pos1 <= '0;
                r_pos2 <= '0;
            end else begin
                if (w_adv1) r_pos1 <= w_dir1 ? r_pos1 - ANGLE_W'(1) : r_pos1 + ANGLE_W'(1);
                if (w_adv2) r_pos2 <= w_dir2 ? r_pos2 - ANGLE_W'(1) : r_pos2 + ANGLE_W'(1);
            end
        end
    end

    assign step1 = w_step1;
    assign step2 = w_step2;
    assign dir1  = w_dir1;
    assign dir2  = w_dir2;
    assign pos1  = r_pos1;
    assign pos2  = r_pos2;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_joint_step_controller.sv
// Directed self-checking bench for joint_step_controller (HALF=2, DIR_SETUP=3).
module tb_joint_step_controller;

    logic               clk;
    logic               reset;
    logic signed [12:0] th1;
    logic signed [12:0] th2;
    logic               angleValid;
    logic               home;
    logic               step1;
    logic               step2;
    logic               dir1;
    logic               dir2;
    logic signed [12:0] pos1;
    logic signed [12:0] pos2;
    logic               busy;
    logic               done;

    int nCmp  = 0;
    int nFail = 0;

    joint_step_controller #(.STEP_HALF_PERIOD(2), .DIR_SETUP(3)) dut (
        .clk(clk), .reset(reset), .th1(th1), .th2(th2), .angleValid(angleValid),
        .home(home), .step1(step1), .step2(step2), .dir1(dir1), .dir2(dir2),
        .pos1(pos1), .pos2(pos2), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        nCmp++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Issues one move and watches every cycle until a few cycles past the
    // expected done; optional angleValid re-rise and home pulse mid-move.
    task automatic applyStimulus(input string tag, input logic signed [12:0] t1,
                                 input logic signed [12:0] t2, input int expLat,
                                 input int expP1, input int expP2, input logic expD1,
                                 input logic expD2, input int riseAt, input int homeAt);
        int   doneAt  = -1;
        int   doneCnt = 0;
        int   p1      = 0;
        int   p2      = 0;
        int   dErr    = 0;
        logic prev1;
        logic prev2;
        th1        = t1;
        th2        = t2;
        angleValid = 1'b1;
        @(posedge clk);
        #1;
        angleValid = 1'b0;
        prev1 = step1;
        prev2 = step2;
        for (int k = 1; k <= expLat + 6; k++) begin
            @(posedge clk);
            #1;
            if (step1 && !prev1) p1++;
            if (step2 && !prev2) p2++;
            if (step1 && (dir1 !== expD1)) dErr++;
            if (step2 && (dir2 !== expD2)) dErr++;
            if (done) begin
                if (doneAt < 0) doneAt = k;
                doneCnt++;
            end
            prev1 = step1;
            prev2 = step2;
            if (k == riseAt) begin
                angleValid = 1'b1;
                th1        = ~t1;
            end
            if (k == homeAt) home = 1'b1;
            else if (k == homeAt + 1) home = 1'b0;
        end
        checkOutput({tag, ".latency"}, doneAt, expLat);
        checkOutput({tag, ".doneCount"}, doneCnt, 1);
        checkOutput({tag, ".pulses1"}, p1, expP1);
        checkOutput({tag, ".pulses2"}, p2, expP2);
        checkOutput({tag, ".dirErrors"}, dErr, 0);
    endtask

    initial begin
        int busySeen;
        reset      = 1'b0;
        th1        = '0;
        th2        = '0;
        angleValid = 1'b0;
        home       = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.outs", {26'b0, step1, step2, dir1, dir2, busy, done}, 0);
        checkOutput("reset.pos1", pos1, 0);
        checkOutput("reset.pos2", pos2, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        applyStimulus("move5m3", 13'sd5, -13'sd3, 25, 5, 3, 1'b0, 1'b1, -1, -1);
        checkOutput("move5m3.pos1", pos1, 5);
        checkOutput("move5m3.pos2", pos2, -3);

        applyStimulus("repeat", 13'sd5, -13'sd3, 2, 0, 0, 1'b0, 1'b1, -1, -1);
        checkOutput("repeat.pos1", pos1, 5);
        checkOutput("repeat.pos2", pos2, -3);

        home = 1'b1;
        @(posedge clk);
        #1;
        home = 1'b0;
        checkOutput("homeIdle1.pos1", pos1, 0);
        checkOutput("homeIdle1.pos2", pos2, 0);

        applyStimulus("minTarget", -13'sd4096, 13'sd0, 16389, 4096, 0, 1'b1, 1'b0, -1, -1);
        checkOutput("minTarget.pos1", pos1, -4096);

        applyStimulus("maxTarget", 13'sd4095, 13'sd0, 32769, 8191, 0, 1'b0, 1'b0, -1, -1);
        checkOutput("maxTarget.pos1", pos1, 4095);

        applyStimulus("ignoreRise", 13'sd4093, 13'sd0, 13, 2, 0, 1'b1, 1'b0, 8, -1);
        checkOutput("ignoreRise.pos1", pos1, 4093);
        busySeen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (busy) busySeen++;
        end
        checkOutput("heldHigh.busy", busySeen, 0);
        checkOutput("heldHigh.pos1", pos1, 4093);
        angleValid = 1'b0;
        th1        = '0;
        repeat (2) @(posedge clk);
        #1;

        th1        = '0;
        th2        = '0;
        angleValid = 1'b1;
        @(posedge clk);
        #1;
        angleValid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("midMove.step1", step1, 1);
        checkOutput("midMove.busy", busy, 1);
        reset = 1'b0;
        #1;
        checkOutput("abort.outs", {26'b0, step1, step2, dir1, dir2, busy, done}, 0);
        checkOutput("abort.pos1", pos1, 0);
        checkOutput("abort.pos2", pos2, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("postAbort.outs", {26'b0, step1, step2, busy, done}, 0);

        applyStimulus("afterAbort", 13'sd2, 13'sd0, 13, 2, 0, 1'b0, 1'b0, -1, -1);
        checkOutput("afterAbort.pos1", pos1, 2);

        applyStimulus("homeBusy", 13'sd7, 13'sd0, 25, 5, 0, 1'b0, 1'b0, -1, 6);
        checkOutput("homeBusy.pos1", pos1, 7);

        home = 1'b1;
        @(posedge clk);
        #1;
        home = 1'b0;
        checkOutput("homeIdle2.pos1", pos1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/joint_step_controller.md
JOINT_STEP_CONTROLLER -- requirements
Module: joint_step_controller

Interface
REQ-001 SHALL have parameter STEP_HALF_PERIOD, default 500, the number of clk cycles step is held high and then held low for each step (minimum 1).
REQ-002 SHALL have parameter DIR_SETUP, default 10, the number of clk cycles dir is held stable before the first step of a move (minimum 1).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port th1  input  13 signed  joint-1 target angle, 1 LSB = 1 motor step.
REQ-006 SHALL have port th2  input  13 signed  joint-2 target angle, 1 LSB = 1 motor step.
REQ-007 SHALL have port angleValid  input  1  level from the angle solver's dataReady; a rising edge requests a move.
REQ-008 SHALL have port home  input  1  when high in Idle, zeroes both position registers.
REQ-009 SHALL have ports step1, step2  output  1 each  step pulses to the motor drivers.
REQ-010 SHALL have ports dir1, dir2  output  1 each  direction, 1 = negative.
REQ-011 SHALL have ports pos1, pos2  output  13 signed each  current joint positions in steps.
REQ-012 SHALL have port busy  output  1  high in every state except Idle.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a move completes.

Function
REQ-014 SHALL register angleValid and detect its rising edge, so a level held high starts exactly one move.
REQ-015 SHALL implement states Idle, Load, DirSetup, Stepping and Done.
REQ-016 Idle: SHALL capture th1/th2 and go to Load on a detected rising edge; home takes priority if both occur in the same cycle.
REQ-017 Load: SHALL compute 14-bit signed delta = target - pos per joint, set dir = delta<0 and remaining = |delta| as 14-bit unsigned (max 8191 magnitude per move within 13-bit range).
REQ-018 Load: SHALL go to Done if both remaining are 0, otherwise go to DirSetup.
REQ-019 DirSetup: SHALL drive dir1/dir2 from the first cycle and stay for DIR_SETUP cycles, then go to Stepping.
REQ-020 Stepping: each joint with remaining>0 SHALL drive step high for STEP_HALF_PERIOD cycles, then low for STEP_HALF_PERIOD cycles.
REQ-021 On the last low cycle of each step, SHALL decrement remaining and update pos by +1 or -1 according to dir.
REQ-022 Both joints SHALL step concurrently on a shared phase; a joint with remaining=0 SHALL hold step low.
REQ-023 SHALL go from Stepping to Done in the cycle after the last step of the longer joint completes.
REQ-024 Done: SHALL assert done for exactly one cycle, then return to Idle.
REQ-025 Latency: done SHALL assert 2+DIR_SETUP+2*STEP_HALF_PERIOD*max(|d1|,|d2|) cycles after the sampling edge, or 2 cycles after when both deltas are 0.
REQ-026 SHALL ignore angleValid edges while busy; there is no queuing.
REQ-027 SHALL ignore home while busy.
REQ-028 dir SHALL NOT change while busy except in Load.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 While reset is low, all state SHALL clear asynchronously: step1, step2, dir1, dir2, busy and done = 0; pos1 and pos2 = 0; state = Idle; edge register = 0.
REQ-031 A reset mid-move SHALL abort the move immediately, with no further pulses and positions zeroed.
REQ-032 After reset, if angleValid is already high, SHALL start no move until angleValid goes low and then high again.

Structure
REQ-033 The state typedef and the angle width constant (13) SHALL live in the shared package scara_pkg.
REQ-034 SHALL use one sub-module, step_pulse_gen, instantiated per joint, holding remaining, dir and the step output, and advanced by the shared phase counter.

Verification
REQ-035 The bench SHALL use HALF=2 and DIR_SETUP=3 and cover these scenarios:
- After reset, th1=5 and th2=-3 with an angleValid rise -> 5 step1 pulses with dir1=0, 3 step2 pulses with dir2=1, final pos1=5 and pos2=-3, a single done pulse 25 cycles after the sampling edge.
- Repeat the same target -> no step pulses, done 2 cycles after the edge.
- Target th1=-4096, then th1=4095 -> 4096 pulses with dir1=1, then 8191 pulses with dir1=0, final pos1=4095.
- An angleValid pulse during Stepping -> ignored; the move finishes unchanged with one done; angleValid held high afterwards starts no new move.
- Reset low in the middle of Stepping -> all outputs 0 within the same cycle; after release, a new th1=2 command -> exactly 2 pulses and pos1=2.
- home=1 in Idle with pos1=7 -> pos1=0 next cycle; home=1 while busy -> no effect.
